// File: rtl/mem_arb_pkg.sv
// Shared defaults and FSM state encoding for the two-port RAM arbiter.
// Optional build macro MEM_ARB_DATA_PRIORITY_EN is consumed by mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way grant function: round-robin on conflict, or fixed data priority
// when MEM_ARB_DATA_PRIORITY_EN is defined (no last-winner input then).
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
`ifndef MEM_ARB_DATA_PRIORITY_EN
    input  logic last,
`endif
    output logic i_win,
    output logic d_win
);

    always_comb begin
        i_win = 1'b0;
        d_win = 1'b0;
`ifdef MEM_ARB_DATA_PRIORITY_EN
        d_win = d_req;
        i_win = i_req & ~d_req;
`else
        // last = 1 means data won most recently, so instruction goes next
        if (i_req && d_req) begin
            i_win = last;
            d_win = ~last;
        end else begin
            i_win = i_req;
            d_win = d_req;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port async-read RAM.
// Define MEM_ARB_DATA_PRIORITY_EN for fixed data priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_spo
);

    arb_state_t state, state_nxt;
    logic       i_win, d_win;

`ifndef MEM_ARB_DATA_PRIORITY_EN
    logic last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (i_gnt) begin
            last <= 1'b0;
        end else if (d_gnt) begin
            last <= 1'b1;
        end
    end
`endif

    mem_arb_pick u_pick (
        .i_req (i_req),
        .d_req (d_req),
`ifndef MEM_ARB_DATA_PRIORITY_EN
        .last  (last),
`endif
        .i_win (i_win),
        .d_win (d_win)
    );

    // Grants are combinational, so reset must mask them directly
    assign i_gnt  = i_win & ~rst;
    assign d_gnt  = d_win & ~rst;
    assign mem_we = d_we & d_gnt;
    assign mem_d  = d_gnt ? d_wdata : '0;

    always_comb begin
        mem_a = '0;
        if (i_gnt) begin
            mem_a = i_addr;
        end else if (d_gnt) begin
            mem_a = d_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (i_gnt) begin
            state_nxt = RESP_I;
        end else if (d_gnt && !d_we) begin
            state_nxt = RESP_D;
        end
    end

    assign i_rvalid = (state == RESP_I);
    assign d_rvalid = (state == RESP_D);

    // Response stage: capture async RAM data at the edge ending the grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rdata <= '0;
        end else if (i_gnt) begin
            i_rdata <= mem_spo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rdata <= '0;
        end else if (d_gnt && !d_we) begin
            d_rdata <= mem_spo;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cases plus randomized traffic
// against a reference memory and grant-rule model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_spo;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d), .mem_spo(mem_spo)
    );

    always #5 clk = ~clk;

    // External RAM emulation and the bench's own reference image
    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    assign mem_spo = ram[mem_a];
    always @(posedge clk) if (mem_we) ram[mem_a] <= mem_d;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          qi[$];
    rsp_t          qd[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            cycle = 0;
    logic          model_last_d = 1'b1;
    int            iwait = 0;
    int            dwait = 0;
    logic [DW-1:0] held_i = '0;
    logic [DW-1:0] held_d = '0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return AW'($urandom_range(0, 31));
    endfunction

    // Monitor: checks response channel every cycle against the scoreboard queues
    always @(negedge clk) begin
        logic ev_i, ev_d;
        if (rst) begin
            chk("reset_outputs", {57'd0, i_gnt, d_gnt, i_rvalid, d_rvalid, mem_we, (|i_rdata), (|d_rdata)}, 64'd0);
            qi.delete();
            qd.delete();
            held_i = '0;
            held_d = '0;
        end else begin
            ev_i = (qi.size() > 0) && (qi[0].due == cycle);
            chk("i_rvalid", i_rvalid, ev_i);
            if (ev_i) begin
                held_i = qi[0].data;
                void'(qi.pop_front());
            end
            chk("i_rdata", i_rdata, held_i);
            ev_d = (qd.size() > 0) && (qd[0].due == cycle);
            chk("d_rvalid", d_rvalid, ev_d);
            if (ev_d) begin
                held_d = qd[0].data;
                void'(qd.pop_front());
            end
            chk("d_rdata", d_rdata, held_d);
        end
    end

    // One arbitration cycle: check grants/RAM port, record expectations, advance
    task automatic run_cycle(output logic gi, output logic gd);
        logic ei, ed;
        @(negedge clk);
        ei = 1'b0;
        ed = 1'b0;
        if (i_req && d_req) begin
`ifdef MEM_ARB_DATA_PRIORITY_EN
            ed = 1'b1;
`else
            if (model_last_d) ei = 1'b1;
            else ed = 1'b1;
`endif
        end else begin
            ei = i_req;
            ed = d_req;
        end
        chk("grant", {i_gnt, d_gnt}, {ei, ed});
        chk("grant_exclusive", i_gnt & d_gnt, 0);
        chk("mem_we", mem_we, ed & d_we);
        chk("mem_a", mem_a, ei ? i_addr : (ed ? d_addr : '0));
        if (ed && d_we) chk("mem_d", mem_d, d_wdata);
`ifndef MEM_ARB_DATA_PRIORITY_EN
        if (i_req) begin
            iwait = i_gnt ? 0 : iwait + 1;
            chk("i_wait_bound", iwait > 1, 0);
        end else iwait = 0;
        if (d_req) begin
            dwait = d_gnt ? 0 : dwait + 1;
            chk("d_wait_bound", dwait > 1, 0);
        end else dwait = 0;
`endif
        if (ei) begin
            model_last_d = 1'b0;
            qi.push_back(rsp_t'{cycle + 1, ref_mem[i_addr]});
        end
        if (ed) begin
            model_last_d = 1'b1;
            if (d_we) ref_mem[d_addr] = d_wdata;
            else qd.push_back(rsp_t'{cycle + 1, ref_mem[d_addr]});
        end
        gi = i_gnt;
        gd = d_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        model_last_d = 1'b1;
        iwait = 0;
        dwait = 0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gi, gd;
        logic [3:0] seq;
        logic [3:0] seq_exp;
        logic [AW-1:0] edge_addr [2];
        gi = 1'b0;
        gd = 1'b0;
        for (int k = 0; k < (1 << AW); k++) begin
            ram[k]     = init_val(k);
            ref_mem[k] = init_val(k);
        end
        ram[4]     = 32'h2001_0005;
        ref_mem[4] = 32'h2001_0005;
        do_reset(3);

        // Instruction fetch alone
        i_req = 1'b1;
        i_addr = 16'h0004;
        run_cycle(gi, gd);
        chk("fetch_rvalid", i_rvalid, 1);
        chk("fetch_rdata", i_rdata, 32'h2001_0005);
        i_req = 1'b0;
        run_cycle(gi, gd);

        // Data write then read back
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 16'h0010;
        d_wdata = 32'hDEAD_BEEF;
        run_cycle(gi, gd);
        chk("write_no_rvalid", d_rvalid, 0);
        d_we = 1'b0;
        run_cycle(gi, gd);
        chk("read_rvalid", d_rvalid, 1);
        chk("read_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        run_cycle(gi, gd);

        // Address extremes
        edge_addr[0] = '0;
        edge_addr[1] = '1;
        for (int k = 0; k < 2; k++) begin
            d_req = 1'b1;
            d_we = 1'b1;
            d_addr = edge_addr[k];
            d_wdata = 32'hA5A5_0000 | 32'(k);
            run_cycle(gi, gd);
            d_we = 1'b0;
            run_cycle(gi, gd);
            chk("edge_rdata", d_rdata, 32'hA5A5_0000 | 32'(k));
            d_req = 1'b0;
            run_cycle(gi, gd);
        end

        // Sustained conflict right after reset
        do_reset(2);
        i_req = 1'b1;
        d_req = 1'b1;
        d_we = 1'b0;
        i_addr = 16'h0008;
        d_addr = 16'h0009;
        for (int k = 0; k < 4; k++) begin
            run_cycle(gi, gd);
            seq[k] = gd;
        end
`ifdef MEM_ARB_DATA_PRIORITY_EN
        seq_exp = 4'b1111;
`else
        seq_exp = 4'b1010;
`endif
        chk("conflict_sequence", seq, seq_exp);
        i_req = 1'b0;
        d_req = 1'b0;
        run_cycle(gi, gd);

        // Reset pulsed while a fetch response is pending
        i_req = 1'b1;
        i_addr = 16'h0004;
        run_cycle(gi, gd);
        rst = 1'b1;
        model_last_d = 1'b1;
        iwait = 0;
        dwait = 0;
        #1;
        chk("rvalid_killed", i_rvalid, 0);
        chk("state_after_reset", dut.state, IDLE);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_cycle(gi, gd);
        chk("post_reset_grant", gi, 1);
        i_req = 1'b0;
        run_cycle(gi, gd);

        // Randomized traffic
        gi = 1'b0;
        gd = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            if (!i_req || gi) begin
                i_req = ($urandom_range(0, 9) < 7);
                i_addr = rand_addr();
            end
            if (!d_req || gd) begin
                d_req = ($urandom_range(0, 9) < 7);
                d_we = ($urandom_range(0, 9) < 4);
                d_addr = rand_addr();
                d_wdata = $urandom;
            end
            run_cycle(gi, gd);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        run_cycle(gi, gd);
        run_cycle(gi, gd);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
